f8_mem_arbiter: RTL and testbench
=================================

Name: f8_mem_arbiter

Overview:
Arbitrates a single-port synchronous system RAM between the f8 core data port (cpu) and a debug/loader port (dbg), e.g. a program loader or trace reader.
- CPU has default priority. A starvation counter guarantees dbg service.
- A lock lets dbg own the bus for multi-byte transfers.
- Sits between the core and RAM inside system; read data returns one cycle after issue, tagged to the issuing requester.

Parameters:
ADDR_WIDTH, 16, RAM address width.
DATA_WIDTH, 8, RAM data width.
STARVE_LIMIT, 4, consecutive CPU grants allowed while dbg_req is pending (legal range 1..15).

Ports:
clk  input  1  system clock, all state on rising edge.
power_on_reset_n  input  1  asynchronous active-low reset.
cpu_req  input  1  CPU access request.
cpu_we  input  1  CPU write (1) / read (0).
cpu_addr  input  ADDR_WIDTH  CPU address.
cpu_wdata  input  DATA_WIDTH  CPU write data.
cpu_gnt  output  1  CPU access issued this cycle.
cpu_rvalid  output  1  CPU read data valid.
cpu_rdata  output  DATA_WIDTH  CPU read data.
dbg_req  input  1  debug access request.
dbg_lock  input  1  hold bus for dbg after the current dbg grant.
dbg_we  input  1  debug write / read.
dbg_addr  input  ADDR_WIDTH  debug address.
dbg_wdata  input  DATA_WIDTH  debug write data.
dbg_gnt  output  1  debug access issued this cycle.
dbg_rvalid  output  1  debug read data valid.
dbg_rdata  output  DATA_WIDTH  debug read data.
mem_en  output  1  RAM enable.
mem_we  output  1  RAM write enable.
mem_addr  output  ADDR_WIDTH  RAM address.
mem_wdata  output  DATA_WIDTH  RAM write data.
mem_rdata  input  DATA_WIDTH  RAM read data, valid the cycle after a read issue.
owner_dbg  output  1  registered: bus currently locked to dbg.

Behaviour:
- Reset (async assert, sync-released by system):
  - state = CPU_PRIO; starve_cnt = 0.
  - rd_pending = 0; owner_dbg = 0; cpu_rvalid = dbg_rvalid = 0.
  - Combinational outputs follow from the zero state: gnt = 0, mem_en = 0 while requests are low.
- Grant is combinational from req and registered state, at most one per cycle:
  - mem_en = cpu_gnt | dbg_gnt.
  - mem_we, mem_addr, mem_wdata muxed from the granted port; all zero when no grant.
- A requester must hold req and its command stable until gnt. gnt = 1 consumes exactly one access. Back-to-back grants to the same port are allowed every cycle.
- FSM states:
  - CPU_PRIO: cpu_req wins. dbg granted only if !cpu_req, or if starve_cnt == STARVE_LIMIT.
    - CPU grant while dbg_req = 1 increments starve_cnt (saturating at STARVE_LIMIT).
    - Any dbg grant, or dbg_req = 0, clears starve_cnt.
    - dbg grant with dbg_lock = 1 moves to DBG_LOCK.
  - DBG_LOCK: owner_dbg = 1; cpu_gnt forced 0; dbg granted whenever dbg_req.
    - Exit to CPU_PRIO (starve_cnt = 0) on the first clock edge with dbg_lock = 0, regardless of dbg_req.
    - A dbg grant in the exit cycle is still issued.
- Read return:
  - A read grant sets rd_pending = 1 and rd_owner = granted port.
  - Next cycle: the matching rvalid = 1 for exactly one cycle, and the matching rdata = mem_rdata.
  - The non-owner rdata is 0. rvalid is registered; rdata is combinational from mem_rdata.
- Reads issued every cycle pipeline fully: one rvalid per read, in issue order, no bubbles.
- Writes produce no rvalid.
- Simultaneous cpu_req & dbg_req in CPU_PRIO with starve_cnt < STARVE_LIMIT: CPU wins.
- Reset mid-read: pending rvalid suppressed; no rvalid after reset release until a new grant.

Test Plan:
- CPU-only reads to 0x0010, 0x0011 on consecutive cycles with RAM preloaded 0xA5, 0x5A -> cpu_gnt both cycles; cpu_rvalid on the next two cycles with cpu_rdata 0xA5 then 0x5A; dbg_rvalid stays 0.
- cpu_req and dbg_req held continuously, STARVE_LIMIT = 4 -> grant pattern C,C,C,C,D repeating; starve_cnt never exceeds 4.
- dbg writes 0x11, 0x22, 0x33 to 0x2000..0x2002 with dbg_lock = 1 through the second grant while cpu_req = 1 -> three consecutive dbg_gnt; owner_dbg = 1 during the lock; cpu_gnt = 0 until the cycle after lock drops; RAM holds 0x11/0x22/0x33.
- CPU read issued, power_on_reset_n asserted the same cycle the data returns -> cpu_rvalid = 0, all outputs zero; after release with no requests, no rvalid for 5 cycles.
- Alternating read/write mix: CPU write 0x7E to 0x0100, dbg read 0x0100 next cycle -> dbg_rvalid with dbg_rdata = 0x7E; cpu_rvalid never asserted.
- dbg_req alone with dbg_lock = 0 in CPU_PRIO -> dbg_gnt the same cycle; state stays CPU_PRIO; starve_cnt = 0.

Source files
------------

// File: rtl/f8_mem_arbiter.sv
// f8_mem_arbiter: shares one synchronous RAM port between the f8 core (cpu)
// and a debug/loader port (dbg). The CPU has priority. A starvation counter
// guarantees that dbg is served. A lock lets dbg hold the bus.
// Ports:
//   cpu_*  core request/grant and read return
//   dbg_*  debug request/lock/grant and read return
//   mem_*  RAM command and read data
//   owner_dbg  bus locked to dbg
module f8_mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  power_on_reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_lock,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  owner_dbg
);

  localparam logic CPU_PRIO = 1'b0;
  localparam logic DBG_LOCK = 1'b1;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic       state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       rd_pending_q, rd_pending_d;
  logic       rd_owner_q, rd_owner_d;
  logic       starved;

  assign starved = (starve_q == LIMIT);

  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    unique case (state_q)
      CPU_PRIO: begin
        dbg_gnt = dbg_req & (~cpu_req | starved);
        cpu_gnt = cpu_req & ~dbg_gnt;
      end
      DBG_LOCK: begin
        dbg_gnt = dbg_req;
      end
      default: ;
    endcase
  end

  assign mem_en = cpu_gnt | dbg_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      cpu_gnt: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      dbg_gnt: begin
        mem_we    = dbg_we;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    unique case (state_q)
      CPU_PRIO: begin
        if (dbg_gnt || !dbg_req) begin
          starve_d = '0;
        end else if (cpu_gnt && !starved) begin
          starve_d = starve_q + 4'd1;
        end
        if (dbg_gnt && dbg_lock) begin
          state_d = DBG_LOCK;
        end
      end
      DBG_LOCK: begin
        // Leaving the lock always restarts fairness from zero.
        if (!dbg_lock) begin
          state_d  = CPU_PRIO;
          starve_d = '0;
        end
      end
      default: ;
    endcase
  end

  // rd_owner: 1 = dbg issued the read, 0 = cpu.
  assign rd_pending_d = mem_en & ~mem_we;
  assign rd_owner_d   = dbg_gnt;

  always_ff @(posedge clk or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      state_q      <= CPU_PRIO;
      starve_q     <= '0;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign owner_dbg  = (state_q == DBG_LOCK);
  assign cpu_rvalid = rd_pending_q & ~rd_owner_q;
  assign dbg_rvalid = rd_pending_q & rd_owner_q;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_f8_mem_arbiter.sv
// tb_f8_mem_arbiter: directed and random stimulus for f8_mem_arbiter,
// checked against a rule-level reference model and a shadow memory.
module tb_f8_mem_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_lock, dbg_we, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          mem_en, mem_we, owner_dbg;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] ram     [0:65535];
  logic [DW-1:0] ref_mem [0:65535];

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  bit          m_locked;
  int          m_streak;
  bit          m_pv;
  bit          m_pdbg;
  logic [DW-1:0] m_pdata;

  f8_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .power_on_reset_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_lock(dbg_lock), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner_dbg(owner_dbg)
  );

  always #5 clk = ~clk;

  // Behavioural single-port synchronous RAM.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_streak = 0;
    m_pv     = 0;
    m_pdbg   = 0;
    m_pdata  = '0;
  endtask

  task automatic drive(input bit cr, input bit cw, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cd, input bit dr, input bit dl,
                       input bit dw, input logic [AW-1:0] da,
                       input logic [DW-1:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_lock = dl; dbg_we = dw; dbg_addr = da;
    dbg_wdata = dd;
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, 0, 0, 0, '0, '0);
  endtask

  // One clock: check everything visible this cycle, then advance model.
  task automatic cycle(output bit gc, output bit gd);
    bit            ec, ed, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    #1;
    if (m_locked) begin
      ec = 0;
      ed = dbg_req;
    end else if (cpu_req && dbg_req) begin
      ed = (m_streak >= LIM);
      ec = !ed;
    end else begin
      ec = cpu_req;
      ed = dbg_req;
    end
    ewe = ec ? cpu_we : (ed ? dbg_we : 1'b0);
    ea  = ec ? cpu_addr : (ed ? dbg_addr : '0);
    ewd = ec ? cpu_wdata : (ed ? dbg_wdata : '0);
    chk("cpu_gnt", cpu_gnt, ec);
    chk("dbg_gnt", dbg_gnt, ed);
    chk("mem_en", mem_en, ec | ed);
    chk("mem_we", mem_we, ewe);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ewd);
    chk("cpu_rvalid", cpu_rvalid, m_pv && !m_pdbg);
    chk("dbg_rvalid", dbg_rvalid, m_pv && m_pdbg);
    chk("cpu_rdata", cpu_rdata, (m_pv && !m_pdbg) ? m_pdata : '0);
    chk("dbg_rdata", dbg_rdata, (m_pv && m_pdbg) ? m_pdata : '0);
    chk("owner_dbg", owner_dbg, m_locked);
    @(posedge clk);
    m_pv    = (ec || ed) && !ewe;
    m_pdbg  = ed;
    m_pdata = ref_mem[ea];
    if ((ec || ed) && ewe) ref_mem[ea] = ewd;
    if (m_locked) begin
      if (!dbg_lock) begin
        m_locked = 0;
        m_streak = 0;
      end
    end else if (ed) begin
      m_streak = 0;
      m_locked = dbg_lock;
    end else if (!dbg_req) begin
      m_streak = 0;
    end else if (ec && m_streak < LIM) begin
      m_streak++;
    end
    gc = ec;
    gd = ed;
    @(negedge clk);
  endtask

  bit gc, gd;
  int dcount;
  bit c_hold, d_hold;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end
    ram[16'h0010] = 8'hA5; ref_mem[16'h0010] = 8'hA5;
    ram[16'h0011] = 8'h5A; ref_mem[16'h0011] = 8'h5A;
    model_reset();
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_owner", owner_dbg, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_dbg_rvalid", dbg_rvalid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // CPU-only consecutive reads
    drive(1, 0, 16'h0010, '0, 0, 0, 0, '0, '0);
    cycle(gc, gd);
    drive(1, 0, 16'h0011, '0, 0, 0, 0, '0, '0);
    cycle(gc, gd);
    idle();
    cycle(gc, gd);
    cycle(gc, gd);

    // Both requesting continuously: C,C,C,C,D pattern
    dcount = 0;
    drive(1, 0, 16'h0010, '0, 1, 0, 0, 16'h0011, '0);
    for (int i = 0; i < 10; i++) begin
      cycle(gc, gd);
      if (gd) dcount++;
      if (i == 4) chk("starve_5th_dbg", gd, 1);
    end
    chk("starve_dbg_count", dcount, 2);
    idle();
    cycle(gc, gd);

    // Locked dbg burst of three writes with cpu waiting
    drive(0, 0, '0, '0, 1, 1, 1, 16'h2000, 8'h11);
    cycle(gc, gd);
    drive(1, 0, 16'h0011, '0, 1, 1, 1, 16'h2001, 8'h22);
    cycle(gc, gd);
    chk("lock_g2", gd, 1);
    drive(1, 0, 16'h0011, '0, 1, 0, 1, 16'h2002, 8'h33);
    cycle(gc, gd);
    chk("lock_g3", gd, 1);
    drive(1, 0, 16'h0011, '0, 0, 0, 0, '0, '0);
    cycle(gc, gd);
    chk("lock_cpu_after", gc, 1);
    idle();
    cycle(gc, gd);
    chk("ram_2000", ram[16'h2000], 8'h11);
    chk("ram_2001", ram[16'h2001], 8'h22);
    chk("ram_2002", ram[16'h2002], 8'h33);

    // CPU write then dbg read-back
    drive(1, 1, 16'h0100, 8'h7E, 0, 0, 0, '0, '0);
    cycle(gc, gd);
    drive(0, 0, '0, '0, 1, 0, 0, 16'h0100, '0);
    cycle(gc, gd);
    idle();
    #1;
    chk("wr_rd_dbg_rdata", dbg_rdata, 8'h7E);
    @(negedge clk);
    // Re-align the model: the last cycle was not stepped through cycle().
    m_pv = 0;

    // dbg alone, no lock
    drive(0, 0, '0, '0, 1, 0, 0, 16'h2001, '0);
    cycle(gc, gd);
    chk("dbg_alone_gnt", gd, 1);
    idle();
    cycle(gc, gd);

    // Reset while read data is returning
    drive(1, 0, 16'h0010, '0, 0, 0, 0, '0, '0);
    cycle(gc, gd);
    idle();
    rst_n = 1'b0;
    #1;
    chk("rstmid_cpu_rvalid", cpu_rvalid, 0);
    chk("rstmid_cpu_rdata", cpu_rdata, 0);
    chk("rstmid_mem_en", mem_en, 0);
    chk("rstmid_owner", owner_dbg, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cycle(gc, gd);

    // Random traffic, requests held until granted
    c_hold = 0;
    d_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!c_hold) begin
        cpu_req   = ($urandom_range(0, 3) != 0);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 16'h0300 + 16'($urandom_range(0, 7));
        cpu_wdata = 8'($urandom);
      end
      if (!d_hold) begin
        dbg_req   = 1'($urandom_range(0, 1));
        dbg_we    = 1'($urandom_range(0, 1));
        dbg_addr  = 16'h0300 + 16'($urandom_range(0, 7));
        dbg_wdata = 8'($urandom);
      end
      dbg_lock = ($urandom_range(0, 3) == 0);
      cycle(gc, gd);
      c_hold = cpu_req && !gc;
      d_hold = dbg_req && !gd;
    end
    idle();
    cycle(gc, gd);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
